idx_buf: RTL and testbench

Ping-pong sparse-index buffer that sits between the index DMA stream and the convolution address generator. The writer side accepts a valid/ready stream of packed index pairs and fills one bank while the address generator reads the other bank through its index read port (address in, index out). Bank ownership is handed over with a full/release handshake, so index loading for the next tile overlaps computation of the current one.

---
 rtl/idx_buf_pkg.sv | 20 ++
 rtl/idx_buf_if.sv | 31 +++
 rtl/idx_buf_bank.sv | 37 +++
 rtl/idx_buf.sv | 170 +++++++++++++++++
 tb/tb_idx_buf.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/idx_buf_pkg.sv
// idx_buf_pkg: shared types and constants for the ping-pong sparse-index buffer.
//   IDX_W           width of one index; one buffer entry holds an index pair
//   IDX_BUF_ADDR_W  default bank address width
//   IDX_BUF_DEPTH   entries per bank
//   idx_entry_t     packed index pair stored in each entry
//   bank_state_e    ownership state of one bank (EMPTY / FULL)
package idx_buf_pkg;

    localparam int IDX_W          = 8;
    localparam int IDX_BUF_ADDR_W = 8;
    localparam int IDX_BUF_DEPTH  = 2**IDX_BUF_ADDR_W;

    typedef logic [IDX_W*2-1:0] idx_entry_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

endpackage

// File: rtl/idx_buf_if.sv
// idx_buf_if: bundle of the writer stream and the reader port of idx_buf.
//   Writer : wr_valid, wr_ready, wr_data, wr_last
//   Reader : rd_valid, rd_cnt, idx_rd_addr, idx, rd_release
//   Status : err (sticky protocol error)
// modport slave is the buffer side, modport master the DMA / address generator side.
interface idx_buf_if #(
    parameter int ADDR_W = idx_buf_pkg::IDX_BUF_ADDR_W
);
    import idx_buf_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    idx_entry_t        wr_data;
    logic              wr_last;
    logic              rd_valid;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] idx_rd_addr;
    idx_entry_t        idx;
    logic              rd_release;
    logic              err;

    modport slave (
        input  wr_valid, wr_data, wr_last, idx_rd_addr, rd_release,
        output wr_ready, rd_valid, rd_cnt, idx, err
    );

    modport master (
        output wr_valid, wr_data, wr_last, idx_rd_addr, rd_release,
        input  wr_ready, rd_valid, rd_cnt, idx, err
    );
endinterface

// File: rtl/idx_buf_bank.sv
// idx_buf_bank: one bank of the ping-pong buffer. Simple dual-port RAM with
// a single write port and a registered read port (1-cycle read latency).
// The RAM contents and read register carry no reset so the array maps onto
// block RAM; the parent masks the output until a valid read has been issued.
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address (sampled every cycle)
//   o_rd_data  read data, one cycle after i_rd_addr
module idx_buf_bank
    import idx_buf_pkg::*;
#(
    parameter int ADDR_W = IDX_BUF_ADDR_W,
    parameter int DEPTH  = IDX_BUF_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  idx_entry_t        i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output idx_entry_t        o_rd_data
);

    idx_entry_t r_mem [DEPTH];
    idx_entry_t r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/idx_buf.sv
// idx_buf: ping-pong sparse-index buffer between the index DMA stream and the
// convolution address generator. The writer fills bank[wr_sel] while the
// reader owns bank[rd_sel]; ownership passes via close (wr_last or bank end)
// and rd_release.
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      idx_buf_if.slave: writer stream, reader port, sticky err
// Build option: define IDX_BUF_RD_REG_EN to add an output register after the
// RAM (read latency 2 instead of 1, idx resets to 0).
module idx_buf
    import idx_buf_pkg::*;
#(
    parameter int ADDR_W = IDX_BUF_ADDR_W
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    idx_buf_if.slave    bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic              r_wr_sel;
    logic              r_rd_sel;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_err;
    logic              r_rd_hit;
    logic              r_rd_bank;

    bank_state_e       w_state [2];
    logic [ADDR_W:0]   w_cnt [2];
    idx_entry_t        w_ram_dout [2];

    logic              w_wr_ready;
    logic              w_rd_valid;
    logic [ADDR_W:0]   w_rd_cnt;
    logic              w_accept;
    logic              w_close;
    logic              w_release;
    idx_entry_t        w_idx_masked;

    // Output decode from registered bank state.
    always_comb begin
        w_wr_ready = (w_state[r_wr_sel] == EMPTY);
        w_rd_valid = (w_state[r_rd_sel] == FULL);
        w_rd_cnt   = w_rd_valid ? w_cnt[r_rd_sel] : '0;
    end

    assign w_accept  = bus.wr_valid & w_wr_ready;
    assign w_close   = w_accept & (bus.wr_last | (r_wr_addr == LAST_ADDR));
    assign w_release = bus.rd_release & w_rd_valid;

    // Per-bank state, count and storage. A close always targets an EMPTY
    // bank and a release a FULL one, so both can act in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            bank_state_e     r_state;
            bank_state_e     w_state_next;
            logic [ADDR_W:0] r_cnt;
            logic            w_is_wr;
            logic            w_is_rd;

            assign w_is_wr = (r_wr_sel == 1'(gi));
            assign w_is_rd = (r_rd_sel == 1'(gi));

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_state <= EMPTY;
                end else begin
                    r_state <= w_state_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                if (w_close && w_is_wr) begin
                    w_state_next = FULL;
                end else if (w_release && w_is_rd) begin
                    w_state_next = EMPTY;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (w_close && w_is_wr) begin
                    r_cnt <= (ADDR_W+1)'(r_wr_addr) + (ADDR_W+1)'(1);
                end else if (w_release && w_is_rd) begin
                    r_cnt <= '0;
                end
            end

            assign w_state[gi] = r_state;
            assign w_cnt[gi]   = r_cnt;

            idx_buf_bank #(
                .ADDR_W (ADDR_W),
                .DEPTH  (2**ADDR_W)
            ) u_bank (
                .i_clk     (i_clk),
                .i_wr_en   (w_accept & w_is_wr),
                .i_wr_addr (r_wr_addr),
                .i_wr_data (bus.wr_data),
                .i_rd_addr (bus.idx_rd_addr),
                .o_rd_data (w_ram_dout[gi])
            );
        end
    endgenerate

    // Write pointer, read pointer and sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_wr_addr <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_close) begin
                    r_wr_addr <= '0;
                    r_wr_sel  <= ~r_wr_sel;
                end else begin
                    r_wr_addr <= r_wr_addr + ADDR_W'(1);
                end
            end
            if (w_release) begin
                r_rd_sel <= ~r_rd_sel;
            end
            if (bus.rd_release && !w_rd_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    // The mask decision and bank choice are taken in the address cycle, in
    // step with the RAM's registered read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_hit  <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            r_rd_hit  <= w_rd_valid && ((ADDR_W+1)'(bus.idx_rd_addr) < w_rd_cnt);
            r_rd_bank <= r_rd_sel;
        end
    end

    assign w_idx_masked = r_rd_hit ? w_ram_dout[r_rd_bank] : '0;

`ifdef IDX_BUF_RD_REG_EN
    idx_entry_t r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
        end else begin
            r_idx <= w_idx_masked;
        end
    end

    assign bus.idx = r_idx;
`else
    assign bus.idx = w_idx_masked;
`endif

    assign bus.wr_ready = w_wr_ready;
    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_cnt   = w_rd_cnt;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_idx_buf.sv
// tb_idx_buf: directed bench for idx_buf. Reads push their expected index
// into a queue; a separate monitor pops and compares when the read data is due.
module tb_idx_buf;
    import idx_buf_pkg::*;

`ifdef IDX_BUF_RD_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    idx_buf_if bus ();

    idx_buf dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       rd_issue = 1'b0;
    idx_entry_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_status(input string tag, input logic wr_rdy, input logic rv,
                              input int cnt, input logic er);
        chk({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(wr_rdy));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(rv));
        chk({tag, ".rd_cnt"},   32'(bus.rd_cnt),   32'(cnt));
        chk({tag, ".err"},      32'(bus.err),      32'(er));
    endtask

    // Scoreboard monitor: a read presented at edge N is due after edge N+RD_LAT-1.
    initial begin
        logic [1:0] pend;
        pend = '0;
        forever begin
            @(posedge clk);
            pend = {pend[0], rd_issue};
            #2;
            if (pend[RD_LAT-1]) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL idx_queue: got read data with no expected entry at %0t", $time);
                end else begin
                    chk("idx", 32'(bus.idx), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    function automatic idx_entry_t pat(input int t, input int i);
        return {8'(t), 8'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        bus.wr_last     = 1'b0;
        bus.rd_release  = 1'b0;
        bus.idx_rd_addr = '0;
        rd_issue        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        chk_status("reset", 1'b1, 1'b0, 0, 1'b0);
        chk("reset.idx", 32'(bus.idx), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!bus.wr_ready && k < 50) begin
            tick();
            k++;
        end
        if (!bus.wr_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_ready_wait: got 0, required 1 within 50 cycles at %0t", $time);
        end
    endtask

    task automatic write_tile(input int t, input int n, input logic use_last);
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = pat(t, i);
            bus.wr_last  = use_last && (i == n - 1);
            wait_ready();
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic rd(input int addr, input idx_entry_t exp);
        bus.idx_rd_addr = 8'(addr);
        rd_issue        = 1'b1;
        exp_q.push_back(exp);
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    task automatic release_pulse();
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        #1;
        // 1: single 5-beat tile, read back, out-of-range masked
        do_reset();
        write_tile(1, 5, 1'b1);
        chk_status("tile5", 1'b1, 1'b1, 5, 1'b0);
        for (int i = 0; i < 5; i++) rd(i, pat(1, i));
        rd(7, '0);
        rd(5, '0);
        drain();

        // 2: three tiles, third stalls until a release
        do_reset();
        write_tile(2, 4, 1'b1);
        write_tile(3, 4, 1'b1);
        chk_status("two_full", 1'b0, 1'b1, 4, 1'b0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = pat(4, 0);
        repeat (3) tick();
        chk("stall.wr_ready", 32'(bus.wr_ready), 32'h0);
        release_pulse();
        chk_status("after_rel", 1'b1, 1'b1, 4, 1'b0);
        write_tile(4, 4, 1'b1);
        chk("third_in.wr_ready", 32'(bus.wr_ready), 32'h0);
        rd(0, pat(3, 0));
        rd(3, pat(3, 3));
        drain();
        release_pulse();
        chk_status("b0_third", 1'b1, 1'b1, 4, 1'b0);
        for (int i = 0; i < 4; i++) rd(i, pat(4, i));
        drain();

        // 3: 256 beats without wr_last auto-close; 257th beat lands in B1
        do_reset();
        write_tile(5, 256, 1'b0);
        chk_status("auto_close", 1'b1, 1'b1, 256, 1'b0);
        rd(0, pat(5, 0));
        rd(128, pat(5, 128));
        rd(255, pat(5, 255));
        write_tile(6, 1, 1'b1);
        chk_status("beat257", 1'b0, 1'b1, 256, 1'b0);
        drain();
        release_pulse();
        chk_status("b1_one", 1'b1, 1'b1, 1, 1'b0);
        rd(0, pat(6, 0));
        rd(1, '0);
        drain();

        // 4: close of B1 and release of B0 in the same cycle
        do_reset();
        write_tile(7, 2, 1'b1);
        write_tile(8, 2, 1'b0);
        bus.wr_valid   = 1'b1;
        bus.wr_data    = pat(8, 2);
        bus.wr_last    = 1'b1;
        bus.rd_release = 1'b1;
        tick();
        idle_inputs();
        chk_status("close_rel", 1'b1, 1'b1, 3, 1'b0);
        rd(2, pat(8, 2));
        rd(0, pat(8, 0));
        rd(3, '0);
        drain();

        // 5: release with nothing to release sets the sticky error
        do_reset();
        release_pulse();
        chk_status("bad_rel", 1'b1, 1'b0, 0, 1'b1);
        repeat (3) tick();
        chk("err_sticky", 32'(bus.err), 32'h1);
        write_tile(9, 1, 1'b1);
        chk_status("err_tile", 1'b1, 1'b1, 1, 1'b1);
        drain();

        // 6: reset mid-tile discards partial data
        do_reset();
        write_tile(10, 3, 1'b0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = pat(10, 3);
        do_reset();
        write_tile(11, 3, 1'b1);
        chk_status("post_rst", 1'b1, 1'b1, 3, 1'b0);
        for (int i = 0; i < 3; i++) rd(i, pat(11, i));
        rd(3, '0);
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
